// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: elastic FIFO between fetch and decode; optional perf counters under FETCH_BUF_PERF_EN
module fetch_decode_buffer #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [ADDR_W-1:0]  if_pc_next,
    output logic               if_ready,
    input  logic               flush,
    input  logic               id_stall,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc_next,
    output logic               overflow_err
`ifdef FETCH_BUF_PERF_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        bubble_cnt
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] HIGH_C = CW'(DEPTH - 2);
    localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0]  mem_pc    [DEPTH];
    logic [CW-1:0]      count, next_count;
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic               pop, push, drop;
    assign id_valid   = count != '0;
    assign id_instr   = id_valid ? mem_instr[rd_ptr] : '0;
    assign id_pc_next = id_valid ? mem_pc[rd_ptr] : '0;
    // flush outranks everything; a full buffer still accepts a push when the head leaves the same edge
    always_comb begin
        pop        = id_valid & ~id_stall & ~flush;
        push       = if_valid & ~flush & ((count != FULL_C) | pop);
        drop       = if_valid & ~flush & (count == FULL_C) & ~pop;
        next_count = flush ? '0 : count + CW'(push) - CW'(pop);
    end
    // occupancy, pointers, early back-pressure (one slot kept for the in-flight ROM word) and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            if_ready     <= 1'b1;
            overflow_err <= 1'b0;
        end else begin
            count        <= next_count;
            if_ready     <= next_count <= HIGH_C;
            overflow_err <= overflow_err | drop;
            rd_ptr       <= flush ? '0 : pop ? ((rd_ptr == LAST_P) ? '0 : rd_ptr + PW'(1)) : rd_ptr;
            wr_ptr       <= flush ? '0 : push ? ((wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1)) : wr_ptr;
        end
    end
    // storage needs no reset: output is gated by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= if_instr;
            mem_pc[wr_ptr]    <= if_pc_next;
        end
    end
`ifdef FETCH_BUF_PERF_EN
    // saturating stall and bubble counters, independent of flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (id_valid & id_stall & (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (~id_valid & ~flush & (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed checks of fetch_decode_buffer (DEPTH=3); perf checks when FETCH_BUF_PERF_EN is defined
module tb_fetch_decode_buffer;
    logic        clk = 1'b0;
    logic        rst, if_valid, flush, id_stall;
    logic [31:0] if_instr;
    logic [9:0]  if_pc_next;
    logic        if_ready, id_valid, overflow_err;
    logic [31:0] id_instr;
    logic [9:0]  id_pc_next;
    int          checks = 0;
    int          failures = 0;
`ifdef FETCH_BUF_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt, s0, b0;
`endif

    fetch_decode_buffer #(.INSTR_W(32), .ADDR_W(10), .DEPTH(3)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc_next(if_pc_next),
        .if_ready(if_ready), .flush(flush), .id_stall(id_stall), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc_next(id_pc_next), .overflow_err(overflow_err)
`ifdef FETCH_BUF_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic st);
        if_valid   = v;
        if_instr   = ins;
        if_pc_next = ins[9:0];
        id_stall   = st;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #2;
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
        chk("rst_ovf", {31'b0, overflow_err}, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_pc", {22'b0, id_pc_next}, 32'd0);
`ifdef FETCH_BUF_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_bubble_cnt", bubble_cnt, 32'd0);
`endif
        #10 rst = 1'b0;
        step();
        // streaming: one instruction per cycle, one-cycle latency
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b0);
            step();
            chk("stream_valid", {31'b0, id_valid}, 32'd1);
            chk("stream_instr", id_instr, 32'(i));
            chk("stream_pc", {22'b0, id_pc_next}, 32'(i));
            chk("stream_ready", {31'b0, if_ready}, 32'd1);
        end
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk("stream_drain_valid", {31'b0, id_valid}, 32'd0);
        chk("stream_drain_instr", id_instr, 32'd0);
        // stall absorb: in-flight word stored, fetch honours if_ready
        drive(1'b1, 32'h10, 1'b0);
        step();
        chk("absorb_ready1", {31'b0, if_ready}, 32'd1);
        drive(1'b1, 32'h11, 1'b1);
        step();
        chk("absorb_ready_low", {31'b0, if_ready}, 32'd0);
        chk("absorb_head", id_instr, 32'h10);
        drive(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("absorb_hold_head", id_instr, 32'h10);
            chk("absorb_hold_ready", {31'b0, if_ready}, 32'd0);
        end
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk("absorb_rel1", id_instr, 32'h11);
        chk("absorb_rel_ready", {31'b0, if_ready}, 32'd1);
        step();
        chk("absorb_rel_empty", {31'b0, id_valid}, 32'd0);
        chk("absorb_ovf", {31'b0, overflow_err}, 32'd0);
        // overflow: pushes ignore if_ready while decode stalls
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'h20 + 32'(i), 1'b1);
            step();
            chk("ovf_head", id_instr, 32'h21);
            chk("ovf_flag", {31'b0, overflow_err}, (i >= 4) ? 32'd1 : 32'd0);
            chk("ovf_ready", {31'b0, if_ready}, (i == 1) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk("ovf_drain1", id_instr, 32'h22);
        step();
        chk("ovf_drain2", id_instr, 32'h23);
        step();
        chk("ovf_drain_empty", {31'b0, id_valid}, 32'd0);
        chk("ovf_sticky", {31'b0, overflow_err}, 32'd1);
        // flush with two entries buffered and a word arriving
        drive(1'b1, 32'h31, 1'b1);
        step();
        drive(1'b1, 32'h32, 1'b1);
        step();
        chk("pre_flush_ready", {31'b0, if_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        step();
        flush = 1'b0;
        chk("flush_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_ready", {31'b0, if_ready}, 32'd1);
        chk("flush_instr", id_instr, 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk("flush_after_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_no_beef", id_instr, 32'd0);
        // asynchronous reset between edges with two entries
        drive(1'b1, 32'h41, 1'b1);
        step();
        drive(1'b1, 32'h42, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        chk("pre_arst_valid", {31'b0, id_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, id_valid}, 32'd0);
        chk("arst_ready", {31'b0, if_ready}, 32'd1);
        chk("arst_ovf", {31'b0, overflow_err}, 32'd0);
        chk("arst_instr", id_instr, 32'd0);
        #1 rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk("arst_after_valid", {31'b0, id_valid}, 32'd0);
        // push+pop while full, pointers wrap
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'h50 + 32'(i), 1'b1);
            step();
        end
        drive(1'b1, 32'h54, 1'b0);
        step();
        chk("full_pp_head", id_instr, 32'h52);
        chk("full_pp_ovf", {31'b0, overflow_err}, 32'd0);
        chk("full_pp_ready", {31'b0, if_ready}, 32'd0);
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk("wrap_drain1", id_instr, 32'h53);
        step();
        chk("wrap_drain2", id_instr, 32'h54);
        chk("wrap_drain2_pc", {22'b0, id_pc_next}, 32'h54);
        step();
        chk("wrap_empty", {31'b0, id_valid}, 32'd0);
`ifdef FETCH_BUF_PERF_EN
        // three stall cycles then two empty cycles
        drive(1'b1, 32'h61, 1'b1);
        step();
        s0 = stall_cnt;
        b0 = bubble_cnt;
        drive(1'b0, 32'h0, 1'b1);
        step(); step(); step();
        drive(1'b0, 32'h0, 1'b0);
        step();
        step(); step();
        chk("perf_stall", stall_cnt - s0, 32'd3);
        chk("perf_bubble", bubble_cnt - b0, 32'd2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Pipeline stage directly downstream of the instruction-fetch block (PC + synchronous instruction ROM); upstream of instruction decode.
- Captures each fetched instruction with its PC+1 value in a small elastic FIFO and presents one instruction per cycle to decode.
- Absorbs the one-cycle ROM read latency: instructions already in flight when decode stalls are kept, not lost.
- Handles branch flush and back-pressures the PC through if_ready.

Parameters:
- INSTR_W, 32, instruction width in bits
- ADDR_W, 10, PC / ROM address width in bits
- DEPTH, 3, FIFO entries; legal 3..8

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  if_instr/if_pc_next hold a valid fetched instruction this cycle
- if_instr  in  INSTR_W  instruction from ROM douta
- if_pc_next  in  ADDR_W  PC+1 belonging to if_instr
- if_ready  out  1  registered; 1 = PC may advance next edge
- flush  in  1  taken branch/jump; discard all buffered and arriving instructions
- id_stall  in  1  decode cannot accept this cycle
- id_valid  out  1  id_instr/id_pc_next are valid
- id_instr  out  INSTR_W  instruction to decode
- id_pc_next  out  ADDR_W  PC+1 to decode
- overflow_err  out  1  sticky: push attempted while full

Behaviour:
- Reset (async, immediate): count=0, rd/wr pointers=0, id_valid=0, id_instr=0, id_pc_next=0, if_ready=1, overflow_err=0. Reset mid-operation drops all entries; no partial output.
- Storage: circular FIFO of DEPTH entries {instr, pc_next}; pointers wrap DEPTH-1 -> 0 (no power-of-two assumption). count is 0..DEPTH.
- Output: head entry drives id_instr/id_pc_next combinationally from storage; id_valid = (count != 0). With count=0, id_instr/id_pc_next = 0.
- Pop: id_valid & !id_stall at an edge removes the head.
- Push: if_valid & !flush at an edge writes tail, if count < DEPTH or a pop occurs the same edge.
- Simultaneous push+pop: count unchanged, both pointers advance; legal when full.
- Full push without pop: entry dropped, overflow_err set and held until rst.
- Back-pressure: if_ready register <= (next_count <= DEPTH-2). Leaves room for the in-flight ROM word issued before fetch sees if_ready low.
- Latency: instruction presented on if_valid at edge N appears on id_* after edge N when buffer was empty. One cycle, no bypass.
- Flush: at the edge, count=0, rd_ptr=wr_ptr=0, and no pop is counted. if_valid in the same cycle is discarded. if_ready=1 next cycle. Decode sees id_valid=0 the cycle after flush.
- flush has priority over push, pop and id_stall. flush with rst: rst wins.
- Occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH-1), HIGH (count>=DEPTH-1, if_ready=0 next), FULL (count=DEPTH). Transitions follow the push/pop rules above.

Optional Feature:
- Macro FETCH_BUF_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle id_valid & id_stall.
  - bubble_cnt increments each cycle !id_valid & !flush.
  - Both reset to 0 on rst, saturate at 0xFFFFFFFF, unaffected by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Streaming: reset, then if_valid=1 with instr 0x00000001..0x00000008, pc_next 1..8, id_stall=0 -> id_valid from cycle 2; id_instr matches in order, one per cycle; if_ready stays 1; count never exceeds 1.
- Stall absorb: stream running, id_stall=1 for 4 cycles while fetch honours if_ready -> if_ready drops one cycle after count reaches 1 (DEPTH=3). In-flight word stored (count 2). No loss or duplication after release; overflow_err=0.
- Overflow: force if_valid=1 ignoring if_ready with id_stall=1 for 5 cycles -> count saturates at 3, 4th+ pushes dropped, overflow_err=1 until rst.
- Flush: buffer holds 2 entries, flush=1 with if_valid=1 (instr 0xDEADBEEF) -> next cycle id_valid=0, count=0, if_ready=1. 0xDEADBEEF never appears on id_instr.
- Async reset mid-stream: assert rst between edges with count=2 -> id_valid=0, if_ready=1 immediately, without waiting for clk.
- FETCH_BUF_PERF_EN: 3 stall cycles then 2 empty cycles -> stall_cnt=3, bubble_cnt=2 (plus initial empty cycles after reset).
